cu_multicycle: RTL and testbench
================================

# cu_multicycle

Parametrised multi-cycle control unit for the 16-bit datapath. It accepts instruction words from the PC/instruction memory path and sequences each one through a fetch/decode/(immediate)/execute/writeback state machine. It drives the register-bank addresses, the ALU select, the PC increment and PC+2 controls, and the branch mux. It adds two-word immediate instructions, a configurable multi-cycle execute stage and a halt state.

## Interface

Parameters:
- INST_W, 16, instruction word width; must satisfy INST_W >= OP_W + 2*RA_W + 1
- OP_W, 5, opcode / ALU select width
- RA_W, 4, register address width
- EXEC_LAT, 1, cycles spent in EXEC (1..15)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- instruction  input  INST_W  instruction or immediate word from instruction memory
- inst_load  input  1  word on `instruction` is valid this cycle
- pc_2_en  output  1  select PC+2 (fetch immediate word)
- pc_inc  output  1  one-cycle pulse: load next PC
- branch_en  output  1  select jump target in branch mux
- wr_en  output  1  register-bank write strobe
- wr_reg  output  RA_W  register-bank write address
- src_reg  output  RA_W  source register read address
- dst_reg  output  RA_W  destination register read address
- op_code  output  OP_W  ALU operation select
- imm_data  output  INST_W  latched immediate word
- halted  output  1  core halted
- stall  input  1  (only with CU_STALL_EN) freeze EXEC

## Operation

- Instruction fields, MSB first: op = [INST_W-1 -: OP_W], dst = next RA_W bits, src = next RA_W bits, bit 0 = IMM flag. All other bits are ignored.
- Opcode classes:
  - 0 = NOP
  - all-ones = HALT
  - all-ones minus 1 = JMP
  - all other values = ALU op with writeback
- States and transitions:
  - FETCH: wait for inst_load=1. On the accepting edge, latch the word into IR, then go to DECODE.
  - DECODE: 1 cycle. Latch src_reg, dst_reg, op_code and wr_reg (= dst) from IR. HALT goes to HALT. IMM=1 goes to IMM. NOP goes to WB. All others go to EXEC.
  - IMM: pc_2_en=1 for the whole state. On inst_load=1, latch imm_data, then go to EXEC, or to WB for NOP.
  - EXEC: down-counter loaded with EXEC_LAT-1 on entry. Leave for WB when the count is 0. branch_en=1 throughout EXEC when op is JMP.
  - WB: 1 cycle. pc_inc=1. wr_en=1 only for the ALU class. Then go to FETCH.
  - HALT: halted=1. All strobes are 0. Leave only on reset.
- Outputs are decoded from the state register and the latched fields only; there is no combinational path from any input to any output.
- src_reg, dst_reg, wr_reg, op_code and imm_data hold their values until the next DECODE (or IMM latch for imm_data).
- inst_load outside FETCH/IMM is ignored.
- JMP still pulses pc_inc in WB; the PC takes the branch target because branch_en was high.

## Timing

- Reset (rst=0, asynchronous): state=FETCH, and all outputs are 0, including halted and all latched fields. Outputs take these values immediately, not at the next edge.
- Release of rst is synchronised internally: the first accepting edge is no earlier than the 2nd rising edge after rst rises.
- Non-immediate ALU op, inst_load accepted at edge 0:
  - DECODE in cycle 1
  - EXEC in cycles 2..1+EXEC_LAT
  - WB in cycle 2+EXEC_LAT
  - next FETCH in cycle 3+EXEC_LAT
- Minimum throughput is one instruction per 4 cycles with EXEC_LAT=1.
- An immediate instruction adds IMM cycles: 1 plus however many cycles inst_load stays low.
- Reset mid-instruction aborts it with no wr_en or pc_inc.
- inst_load held high continuously: one word is accepted per FETCH/IMM entry only.

## Configuration

- CU_STALL_EN defined:
  - The `stall` input exists.
  - While stall=1 in EXEC, the counter and state freeze, and op_code and branch_en hold.
  - stall is ignored in every other state.
- CU_STALL_EN undefined:
  - The port is absent.
  - EXEC always lasts exactly EXEC_LAT cycles.

## Test plan

All scenarios use defaults: INST_W=16, OP_W=5, RA_W=4.

1. Reset: drive rst=0 mid-EXEC of 0x09A8 -> all outputs 0 immediately. After release, the FSM is in FETCH and no wr_en/pc_inc pulse occurs for the aborted instruction.
2. ALU op: 0x09A8 (op=1, dst=3, src=5) with EXEC_LAT=1 -> from cycle 2, op_code=1, src_reg=5, dst_reg=3. In cycle 3, wr_en=1, wr_reg=3, pc_inc=1. Cycle 4 is FETCH.
3. Immediate: 0x09A9, then hold inst_load low for 3 cycles, then present 0x1234 -> pc_2_en=1 for 4 cycles, imm_data=0x1234, then EXEC, then WB with wr_en=1.
4. JMP then HALT: 0xF000 -> branch_en=1 in EXEC, wr_en=0 in WB, pc_inc=1. Then 0xF800 -> halted=1 from cycle 2 after acceptance. Further inst_load pulses produce no strobes.
5. EXEC_LAT=4: 0x09A8 -> op_code held for 4 cycles, and wr_en appears in cycle 6.
6. With CU_STALL_EN: stall=1 for 3 cycles during EXEC -> WB is delayed by exactly 3 cycles and op_code stays stable throughout. NOP 0x0000 -> a WB pulse with pc_inc=1 and wr_en=0.

Source files
------------

// File: rtl/cu_multicycle.sv
// ---------------------------------------------------------------------------
// cu_multicycle
//   Multi-cycle control unit for the 16-bit datapath. Each instruction word is
//   sequenced through FETCH -> DECODE -> (IMM) -> EXEC -> WB. Two-word
//   immediate instructions fetch their second word through the PC+2 path.
//   HALT parks the unit until reset.
//
//   Every output is a flop. Strobes are computed from the next state, so they
//   line up with the state they belong to. There is no combinational path
//   from any input to any output.
//
// Parameters
//   INST_W   instruction word width (>= OP_W + 2*RA_W + 1)
//   OP_W     opcode / ALU select width
//   RA_W     register address width
//   EXEC_LAT cycles spent in EXEC (1..15)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset; release is synchronised inside
//   instruction  instruction or immediate word from instruction memory
//   inst_load    word on instruction is valid this cycle
//   pc_2_en      select PC+2 while fetching the immediate word
//   pc_inc       one-cycle pulse in WB: load next PC
//   branch_en    select the jump target for the whole of EXEC of a JMP
//   wr_en        register-bank write strobe (ALU class only, in WB)
//   wr_reg       register-bank write address
//   src_reg      source register read address
//   dst_reg      destination register read address
//   op_code      ALU operation select
//   imm_data     latched immediate word
//   halted       core halted
//   stall        freezes EXEC (present only when CU_STALL_EN is defined)
//
// Build option
//   CU_STALL_EN  adds the stall input; without it EXEC is exactly EXEC_LAT
// ---------------------------------------------------------------------------
module cu_multicycle #(
    parameter int INST_W   = 16,
    parameter int OP_W     = 5,
    parameter int RA_W     = 4,
    parameter int EXEC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] instruction,
    input  logic              inst_load,
    output logic              pc_2_en,
    output logic              pc_inc,
    output logic              branch_en,
    output logic              wr_en,
    output logic [RA_W-1:0]   wr_reg,
    output logic [RA_W-1:0]   src_reg,
    output logic [RA_W-1:0]   dst_reg,
    output logic [OP_W-1:0]   op_code,
    output logic [INST_W-1:0] imm_data,
    output logic              halted
`ifdef CU_STALL_EN
    ,
    input  logic              stall
`endif
);

    // Field positions, MSB first: op, dst, src ... imm flag at bit 0.
    localparam int DST_MSB = INST_W - OP_W - 1;
    localparam int SRC_MSB = DST_MSB - RA_W;

    localparam logic [OP_W-1:0] OP_NOP  = '0;
    localparam logic [OP_W-1:0] OP_HALT = '1;
    localparam logic [OP_W-1:0] OP_JMP  = {{(OP_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]      LAT_M1  = 4'(EXEC_LAT - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_IMM,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [OP_W-1:0]   ir_op;
    logic [RA_W-1:0]   ir_dst;
    logic [RA_W-1:0]   ir_src;
    logic              ir_imm;
    logic [3:0]        cnt;
    logic [1:0]        rst_sync;
    logic              run;
    logic              hold;
    logic              is_nop;
    logic              is_jmp;
    logic              is_halt;
    logic              is_alu;

`ifdef CU_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // The opcode class comes from IR. IR stays stable from the accepting
    // edge in FETCH until the next acceptance.
    assign is_nop  = (ir_op == OP_NOP);
    assign is_jmp  = (ir_op == OP_JMP);
    assign is_halt = (ir_op == OP_HALT);
    assign is_alu  = !(is_nop || is_jmp || is_halt);

    // Reset asserts immediately. Release goes through two flops, so the
    // first instruction can only be accepted on the third edge after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments keep the shift register a true
            // two-stage pipe; blocking ones would collapse it into one flop.
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign run = rst_sync[1];

    always_comb begin
        // NOTE: next state defaults to the current state before the case, so
        // no path leaves state_nx unassigned and no latch is inferred.
        state_nx = state;
        unique case (state)
            S_FETCH:  if (inst_load && run) state_nx = S_DECODE;
            S_DECODE: begin
                if (is_halt)     state_nx = S_HALT;
                else if (ir_imm) state_nx = S_IMM;
                else if (is_nop) state_nx = S_WB;
                else             state_nx = S_EXEC;
            end
            S_IMM:    if (inst_load) state_nx = is_nop ? S_WB : S_EXEC;
            S_EXEC:   if (!hold && cnt == 4'd0) state_nx = S_WB;
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every register is reset here, including the latched
            // fields, so all outputs read zero as soon as rst falls.
            state     <= S_FETCH;
            ir_op     <= '0;
            ir_dst    <= '0;
            ir_src    <= '0;
            ir_imm    <= 1'b0;
            cnt       <= '0;
            pc_2_en   <= 1'b0;
            pc_inc    <= 1'b0;
            branch_en <= 1'b0;
            wr_en     <= 1'b0;
            wr_reg    <= '0;
            src_reg   <= '0;
            dst_reg   <= '0;
            op_code   <= '0;
            imm_data  <= '0;
            halted    <= 1'b0;
        end else begin
            state <= state_nx;

            // Strobes are registered from the next state, so each one is
            // high exactly while the matching state is current.
            pc_2_en   <= (state_nx == S_IMM);
            pc_inc    <= (state_nx == S_WB);
            wr_en     <= (state_nx == S_WB) && is_alu;
            branch_en <= (state_nx == S_EXEC) && is_jmp;
            halted    <= (state_nx == S_HALT);

            if (state == S_FETCH && state_nx == S_DECODE) begin
                ir_op  <= instruction[INST_W-1 -: OP_W];
                ir_dst <= instruction[DST_MSB -: RA_W];
                ir_src <= instruction[SRC_MSB -: RA_W];
                ir_imm <= instruction[0];
            end

            if (state == S_DECODE) begin
                op_code <= ir_op;
                dst_reg <= ir_dst;
                wr_reg  <= ir_dst;
                src_reg <= ir_src;
            end

            if (state == S_IMM && inst_load) begin
                imm_data <= instruction;
            end

            // Load the counter on entry to EXEC. Count down while not stalled.
            if (state_nx == S_EXEC && state != S_EXEC) begin
                cnt <= LAT_M1;
            end else if (state == S_EXEC && !hold && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_cu_multicycle.sv
// ---------------------------------------------------------------------------
// tb_cu_multicycle
//   Scoreboard bench for cu_multicycle. Two instances are used: EXEC_LAT=1 as
//   index 0 and EXEC_LAT=4 as index 1. They share the instruction, rst and
//   stall inputs and each has its own inst_load.
//   The stimulus pushes the expected WB record, with the time it must appear,
//   when each instruction is accepted. A negedge monitor pops and compares a
//   record whenever pc_inc is seen.
// ---------------------------------------------------------------------------
module tb_cu_multicycle;

    typedef struct {
        time         t;
        logic        wr;
        logic [3:0]  wreg;
        logic [4:0]  op;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [15:0] imm;
        int          npc2;
        int          nbr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic [1:0]  ld;
`ifdef CU_STALL_EN
    logic        stall;
`endif

    logic        a_pc2, a_inc, a_br, a_wr, a_halt;
    logic [3:0]  a_wreg, a_src, a_dst;
    logic [4:0]  a_op;
    logic [15:0] a_imm;
    logic        b_pc2, b_inc, b_br, b_wr, b_halt;
    logic [3:0]  b_wreg, b_src, b_dst;
    logic [4:0]  b_op;
    logic [15:0] b_imm;

    exp_t sb0[$];
    exp_t sb1[$];
    int   npc2_cnt[2];
    int   nbr_cnt[2];
    int   n_cmp;
    int   n_bad;

    cu_multicycle #(.EXEC_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .instruction(instruction), .inst_load(ld[0]),
        .pc_2_en(a_pc2), .pc_inc(a_inc), .branch_en(a_br), .wr_en(a_wr),
        .wr_reg(a_wreg), .src_reg(a_src), .dst_reg(a_dst), .op_code(a_op),
        .imm_data(a_imm), .halted(a_halt)
`ifdef CU_STALL_EN
        , .stall(stall)
`endif
    );

    cu_multicycle #(.EXEC_LAT(4)) u_lat4 (
        .clk(clk), .rst(rst), .instruction(instruction), .inst_load(ld[1]),
        .pc_2_en(b_pc2), .pc_inc(b_inc), .branch_en(b_br), .wr_en(b_wr),
        .wr_reg(b_wreg), .src_reg(b_src), .dst_reg(b_dst), .op_code(b_op),
        .imm_data(b_imm), .halted(b_halt)
`ifdef CU_STALL_EN
        , .stall(stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic mon(input int idx, input logic pci, input logic wre, input logic bre,
                       input logic p2e, input logic [3:0] wreg, input logic [3:0] src,
                       input logic [3:0] dst, input logic [4:0] op, input logic [15:0] imm);
        exp_t e;
        if (!rst) begin
            npc2_cnt[idx] = 0;
            nbr_cnt[idx]  = 0;
            return;
        end
        if (bre) nbr_cnt[idx]++;
        if (p2e) npc2_cnt[idx]++;
        if (wre) check($sformatf("d%0d_wr_en_without_pc_inc", idx), 64'(pci), 64'd1);
        if (pci) begin
            if ((idx == 0 && sb0.size() == 0) || (idx == 1 && sb1.size() == 0)) begin
                check($sformatf("d%0d_unexpected_pc_inc", idx), 64'(pci), 64'd0);
            end else begin
                e = (idx == 0) ? sb0.pop_front() : sb1.pop_front();
                check($sformatf("d%0d_wb_time", idx), 64'($time), 64'(e.t));
                check($sformatf("d%0d_wr_en", idx), 64'(wre), 64'(e.wr));
                check($sformatf("d%0d_wr_reg", idx), 64'(wreg), 64'(e.wreg));
                check($sformatf("d%0d_op_code", idx), 64'(op), 64'(e.op));
                check($sformatf("d%0d_src_reg", idx), 64'(src), 64'(e.src));
                check($sformatf("d%0d_dst_reg", idx), 64'(dst), 64'(e.dst));
                check($sformatf("d%0d_imm_data", idx), 64'(imm), 64'(e.imm));
                check($sformatf("d%0d_pc_2_en_cycles", idx), 64'(npc2_cnt[idx]), 64'(e.npc2));
                check($sformatf("d%0d_branch_en_cycles", idx), 64'(nbr_cnt[idx]), 64'(e.nbr));
            end
            npc2_cnt[idx] = 0;
            nbr_cnt[idx]  = 0;
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_inc, a_wr, a_br, a_pc2, a_wreg, a_src, a_dst, a_op, a_imm);
        mon(1, b_inc, b_wr, b_br, b_pc2, b_wreg, b_src, b_dst, b_op, b_imm);
    end

    // Presents one instruction (plus an immediate word after gap idle IMM
    // cycles when gap >= 0). Returns in cycle 1 for plain words, or in the
    // cycle after the immediate word is accepted.
    // wb_cyc is the WB cycle counted from the accepting edge (edge 0).
    task automatic issue(input int idx, input logic [15:0] word, input int gap,
                         input logic [15:0] immw, input bit push, input int wb_cyc,
                         input logic wr, input logic [3:0] wreg, input logic [4:0] op,
                         input logic [3:0] src, input logic [3:0] dst,
                         input logic [15:0] imm_e, input int npc2_e, input int nbr_e);
        exp_t e;
        time  t0;
        @(negedge clk);
        instruction = word;
        ld[idx] = 1'b1;
        @(posedge clk);
        t0 = $time;
        if (push) begin
            e.t = t0 + 64'(10 * (wb_cyc - 1) + 5);
            e.wr = wr; e.wreg = wreg; e.op = op; e.src = src; e.dst = dst;
            e.imm = imm_e; e.npc2 = npc2_e; e.nbr = nbr_e;
            if (idx == 0) sb0.push_back(e); else sb1.push_back(e);
        end
        @(negedge clk);
        ld[idx] = 1'b0;
        if (gap >= 0) begin
            repeat (1 + gap) @(negedge clk);
            instruction = immw;
            ld[idx] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ld[idx] = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && (sb0.size() != 0 || sb1.size() != 0); i++) @(negedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(sb0.size() + sb1.size()), 64'd0);
    endtask

    initial begin
        exp_t e;
        time  t0;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        ld = 2'b00;
        instruction = 16'h0000;
`ifdef CU_STALL_EN
        stall = 1'b0;
`endif
        #3;
        check("reset_strobes", 64'({a_pc2, a_inc, a_br, a_wr, a_halt}), 64'd0);
        check("reset_fields", 64'({a_wreg, a_src, a_dst, a_op}), 64'd0);
        check("reset_imm", 64'(b_imm), 64'd0);
        #20 rst = 1'b1;
        repeat (4) @(negedge clk);

        // ALU op 0x09A8: op=1 dst=3 src=5, WB in cycle 3
        issue(0, 16'h09A8, -1, 16'h0, 1, 3, 1'b1, 4'd3, 5'd1, 4'd5, 4'd3, 16'h0000, 0, 0);
        wait_drain();

        // Immediate: 0x09A9, 3 idle IMM cycles, then 0x1234 -> 4 IMM cycles, WB cycle 7
        issue(0, 16'h09A9, 3, 16'h1234, 1, 7, 1'b1, 4'd3, 5'd1, 4'd5, 4'd3, 16'h1234, 4, 0);
        wait_drain();

        // NOP: DECODE straight to WB in cycle 2, no write, imm_data kept
        issue(0, 16'h0000, -1, 16'h0, 1, 2, 1'b0, 4'd0, 5'd0, 4'd0, 4'd0, 16'h1234, 0, 0);
        wait_drain();

        // JMP 0xF000 (op=30): one branch_en cycle, WB in cycle 3 with pc_inc only
        issue(0, 16'hF000, -1, 16'h0, 1, 3, 1'b0, 4'd0, 5'd30, 4'd0, 4'd0, 16'h1234, 0, 1);
        wait_drain();

        // HALT 0xF800: halted from cycle 2, later loads do nothing
        issue(0, 16'hF800, -1, 16'h0, 0, 0, 1'b0, 4'd0, 5'd0, 4'd0, 4'd0, 16'h0, 0, 0);
        check("halt_cycle1", 64'(a_halt), 64'd0);
        @(negedge clk);
        check("halt_cycle2", 64'(a_halt), 64'd1);
        check("halt_pc_2_en", 64'(a_pc2), 64'd0);
        instruction = 16'h09A8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) ld[0] = ~ld[0];
        end
        ld[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("halt_held", 64'({a_halt, a_inc, a_wr, a_br}), 64'b1000);

        // EXEC_LAT=4: op_code held in cycles 2..5, WB in cycle 6
        issue(1, 16'h09A8, -1, 16'h0, 1, 6, 1'b1, 4'd3, 5'd1, 4'd5, 4'd3, 16'h0000, 0, 0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check($sformatf("lat4_op_code_c%0d", k), 64'(b_op), 64'd1);
            check($sformatf("lat4_no_wr_c%0d", k), 64'(b_wr), 64'd0);
        end
        wait_drain();

        // inst_load held high: one word per FETCH entry, accepts at edges 0 and 7
        @(negedge clk);
        instruction = 16'h09A8;
        ld[1] = 1'b1;
        @(posedge clk);
        t0 = $time;
        e.wr = 1'b1; e.wreg = 4'd3; e.op = 5'd1; e.src = 4'd5; e.dst = 4'd3;
        e.imm = 16'h0000; e.npc2 = 0; e.nbr = 0;
        e.t = t0 + 64'(10 * 5 + 5);
        sb1.push_back(e);
        e.t = t0 + 64'(10 * 12 + 5);
        sb1.push_back(e);
        repeat (9) @(negedge clk);
        ld[1] = 1'b0;
        wait_drain();

`ifdef CU_STALL_EN
        // Stall 3 cycles in EXEC (cycles 3..5): WB moves from cycle 6 to 9
        issue(1, 16'h09A8, -1, 16'h0, 1, 9, 1'b1, 4'd3, 5'd1, 4'd5, 4'd3, 16'h0000, 0, 0);
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        for (int k = 3; k <= 5; k++) begin
            check($sformatf("stall_op_code_c%0d", k), 64'(b_op), 64'd1);
            @(negedge clk);
        end
        stall = 1'b0;
        check("stall_op_code_c6", 64'(b_op), 64'd1);
        wait_drain();
`endif

        // Reset mid-EXEC of 0x09A8 on the EXEC_LAT=4 unit: outputs clear at once
        issue(1, 16'h09A8, -1, 16'h0, 0, 0, 1'b0, 4'd0, 5'd0, 4'd0, 4'd0, 16'h0, 0, 0);
        repeat (2) @(negedge clk);
        check("pre_reset_op_code", 64'(b_op), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_fields", 64'({b_op, b_src, b_dst, b_wreg}), 64'd0);
        check("abort_strobes", 64'({b_pc2, b_inc, b_br, b_wr, b_halt}), 64'd0);
        check("abort_halted_cleared", 64'(a_halt), 64'd0);
        check("abort_imm_cleared", 64'(a_imm), 64'd0);
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        repeat (12) @(negedge clk);

        // Both units back in FETCH after release
        issue(1, 16'h09A8, -1, 16'h0, 1, 6, 1'b1, 4'd3, 5'd1, 4'd5, 4'd3, 16'h0000, 0, 0);
        wait_drain();
        issue(0, 16'h09A8, -1, 16'h0, 1, 3, 1'b1, 4'd3, 5'd1, 4'd5, 4'd3, 16'h0000, 0, 0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "time limit");
    end

endmodule
